// File: rtl/bcd_scan_mux.sv
// bcd_scan_mux: time-multiplexed BCD display driver with a sign position,
// leading-zero blanking, anti-ghost guard cycles and a frame-aligned
// double buffer so that a displayed frame never mixes two values.
module bcd_scan_mux #(
   parameter int unsigned NUM_DIGITS = 5,
   parameter int unsigned DIV        = 100000,
   parameter int unsigned GUARD      = 2,
   parameter bit          LZB_EN     = 1'b1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 enable,
   input  logic [4*NUM_DIGITS-1:0]              digits_in,
   input  logic                                 sign_neg,
   input  logic                                 load,
   output logic [NUM_DIGITS:0]                  digit_sel,
   output logic [3:0]                           digit_code,
   output logic                                 blank,
   output logic [$clog2(NUM_DIGITS+1)-1:0]      scan_idx,
   output logic                                 frame_done,
   output logic                                 pending
);

   localparam int unsigned DW    = 4 * NUM_DIGITS;
   localparam int unsigned SELW  = NUM_DIGITS + 1;
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);
   localparam int unsigned CNT_W = (DIV <= 2) ? 1 : $clog2(DIV);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [IDX_W-1:0] idx_n;
   logic             tick_c;
   logic             wrap_c;
   logic             guard_ok_c;

   logic [DW-1:0]    act_dig;
   logic [DW-1:0]    act_dig_n;
   logic             act_sign;
   logic             act_sign_n;
   logic [DW-1:0]    pend_dig;
   logic [DW-1:0]    pend_dig_n;
   logic             pend_sign;
   logic             pend_sign_n;
   logic             pending_n;

   logic [SELW-1:0]  sel_n;
   logic [3:0]       code_n;
   logic             blank_n;
   logic             fd_n;

   // Prescaler and position counter next state; both held at zero while disabled.
   always_comb begin
      cnt_n  = '0;
      idx_n  = '0;
      tick_c = enable && (cnt == CNT_W'(DIV - 1));
      wrap_c = tick_c && (scan_idx == IDX_W'(NUM_DIGITS));
      if (enable) begin
         if (tick_c) begin
            cnt_n = '0;
            idx_n = wrap_c ? '0 : scan_idx + IDX_W'(1);
         end else begin
            cnt_n = cnt + CNT_W'(1);
            idx_n = scan_idx;
         end
      end
   end

   // Double buffer: loads park in the pending buffer and move to the active
   // buffer only at the frame wrap; a load on the wrap edge bypasses straight in.
   always_comb begin
      act_dig_n   = act_dig;
      act_sign_n  = act_sign;
      pend_dig_n  = pend_dig;
      pend_sign_n = pend_sign;
      pending_n   = pending;
      if (wrap_c) begin
         if (load) begin
            act_dig_n  = digits_in;
            act_sign_n = sign_neg;
         end else if (pending) begin
            act_dig_n  = pend_dig;
            act_sign_n = pend_sign;
         end
         pending_n = 1'b0;
      end else if (load) begin
         pend_dig_n  = digits_in;
         pend_sign_n = sign_neg;
         pending_n   = 1'b1;
      end
   end

   // Guard window: the selected position stays dark for the first GUARD cycles of a slot.
   generate
      if (GUARD == 0) begin : g_no_guard
         assign guard_ok_c = 1'b1;
      end else begin : g_guard
         assign guard_ok_c = (cnt_n >= CNT_W'(GUARD));
      end
   endgenerate

   // Output decode from next-state values so outputs move on the same edge as the counters.
   always_comb begin
      logic zero_run;
      sel_n    = '1;
      code_n   = 4'h0;
      blank_n  = 1'b0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (act_dig_n[4*k +: 4] == 4'h0);
         if (idx_n == IDX_W'(k)) begin
            code_n  = act_dig_n[4*k +: 4];
            blank_n = LZB_EN && (k != 0) && zero_run;
         end
      end
      if (idx_n == IDX_W'(NUM_DIGITS)) begin
         code_n  = act_sign_n ? 4'hA : 4'h0;
         blank_n = !act_sign_n;
      end
      for (int k = 0; k < int'(SELW); k++) begin
         if (enable && guard_ok_c && (idx_n == IDX_W'(k))) begin
            sel_n[k] = 1'b0;
         end
      end
      fd_n = (cnt_n == CNT_W'(DIV - 1)) && (idx_n == IDX_W'(NUM_DIGITS));
   end

   // State and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         scan_idx   <= '0;
         act_dig    <= '0;
         act_sign   <= 1'b0;
         pend_dig   <= '0;
         pend_sign  <= 1'b0;
         pending    <= 1'b0;
         digit_sel  <= '1;
         digit_code <= 4'h0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         scan_idx   <= idx_n;
         act_dig    <= act_dig_n;
         act_sign   <= act_sign_n;
         pend_dig   <= pend_dig_n;
         pend_sign  <= pend_sign_n;
         pending    <= pending_n;
         digit_sel  <= sel_n;
         digit_code <= code_n;
         blank      <= blank_n;
         frame_done <= fd_n;
      end
   end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// tb_bcd_scan_mux: directed and randomized stimulus for bcd_scan_mux,
// checked against a frame-time reference model.
module tb_bcd_scan_mux;

   localparam int unsigned N     = 4;
   localparam int unsigned DIV   = 4;
   localparam int unsigned GUARD = 1;
   localparam int unsigned P     = DIV * (N + 1);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [15:0] digits_in;
   logic        sign_neg;
   logic        load;
   logic [4:0]  digit_sel;
   logic [3:0]  digit_code;
   logic        blank;
   logic [2:0]  scan_idx;
   logic        frame_done;
   logic        pending;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: time within the frame plus the two buffers.
   int unsigned m_t;
   logic [15:0] m_act, m_pend;
   logic        m_sa, m_sp, m_pending, m_rst, m_en;

   bcd_scan_mux #(.NUM_DIGITS(N), .DIV(DIV), .GUARD(GUARD), .LZB_EN(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .digits_in  (digits_in),
      .sign_neg   (sign_neg),
      .load       (load),
      .digit_sel  (digit_sel),
      .digit_code (digit_code),
      .blank      (blank),
      .scan_idx   (scan_idx),
      .frame_done (frame_done),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      if (!rst_n) begin
         m_t = 0; m_act = '0; m_pend = '0; m_sa = 0; m_sp = 0;
         m_pending = 0; m_rst = 1; m_en = 0;
      end else begin
         m_rst = 0;
         m_en  = enable;
         if (enable && m_t == P - 1) begin
            if (load) begin
               m_act = digits_in; m_sa = sign_neg;
            end else if (m_pending) begin
               m_act = m_pend; m_sa = m_sp;
            end
            m_pending = 0;
         end else if (load) begin
            m_pend = digits_in; m_sp = sign_neg; m_pending = 1;
         end
         m_t = enable ? (m_t + 1) % P : 0;
      end
   endtask

   task automatic check_outputs();
      int unsigned pos, c;
      logic [4:0]  e_sel;
      logic [3:0]  e_code;
      logic        e_blank, e_fd;
      logic [15:0] upper;
      if (m_rst) begin
         e_sel = 5'b11111; e_code = 4'h0; e_blank = 1'b1; pos = 0; e_fd = 1'b0;
      end else begin
         pos   = m_t / DIV;
         c     = m_t % DIV;
         e_sel = 5'b11111;
         if (m_en && c >= GUARD) e_sel[pos] = 1'b0;
         e_fd  = (m_t == P - 1);
         if (pos < N) begin
            upper   = m_act >> (4 * pos);
            e_code  = 4'(upper & 16'hF);
            e_blank = (pos >= 1) && (upper == 16'h0);
         end else begin
            e_code  = m_sa ? 4'hA : 4'h0;
            e_blank = !m_sa;
         end
      end
      chk("digit_sel",  8'(digit_sel),  8'(e_sel));
      chk("digit_code", 8'(digit_code), 8'(e_code));
      chk("blank",      8'(blank),      8'(e_blank));
      chk("scan_idx",   8'(scan_idx),   8'(pos));
      chk("frame_done", 8'(frame_done), 8'(e_fd));
      chk("pending",    8'(pending),    8'(m_rst ? 1'b0 : m_pending));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
   endtask

   // Run until the model reaches frame time 'target', bounded to one frame.
   task automatic wait_t(input int unsigned target);
      for (int i = 0; i < int'(P) + 2 && m_t != target; i++) cycle();
      compared++;
      assert (m_t == target) else begin
         mismatched++;
         $error("FAIL wait_t observed=%0d expected=%0d", m_t, target);
      end
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] d;
      d = 16'($urandom);
      d = d >> (4 * $urandom_range(0, 4));
      return d;
   endfunction

   initial begin
      m_t = 0; m_act = '0; m_pend = '0; m_sa = 0; m_sp = 0;
      m_pending = 0; m_rst = 1; m_en = 0;
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; digits_in = '0; sign_neg = 1'b0;

      // Reset state
      repeat (2) cycle();

      // Free-running scan with all-zero buffers
      rst_n = 1'b1; enable = 1'b1;
      repeat (45) cycle();

      // Mid-frame load of 0305 with negative sign
      digits_in = 16'h0305; sign_neg = 1'b1; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (25) cycle();

      // Two loads in one frame: only the second reaches the display
      wait_t(2);
      digits_in = 16'h0012; sign_neg = 1'b0; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (4) cycle();
      digits_in = 16'h0099; load = 1'b1;
      cycle();
      load = 1'b0;
      repeat (25) cycle();

      // Load on the frame_done cycle goes straight to the display
      wait_t(P - 1);
      chk("frame_done_at_wrap", 8'(frame_done), 8'd1);
      digits_in = 16'h1234; sign_neg = 1'b0; load = 1'b1;
      cycle();
      load = 1'b0;
      chk("pending_after_direct", 8'(pending), 8'd0);
      chk("code_after_direct", 8'(digit_code), 8'h4);
      repeat (22) cycle();

      // Enable dropped mid-slot, then restored
      wait_t(9);
      enable = 1'b0;
      repeat (3) cycle();
      enable = 1'b1;
      repeat (10) cycle();

      // Reset mid-frame discards a pending value
      wait_t(4);
      digits_in = 16'h0870; sign_neg = 1'b1; load = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      repeat (25) cycle();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst_n = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 59) == 0) enable = !enable;
         load = ($urandom_range(0, 5) == 0);
         if (load) begin
            digits_in = rand_digits();
            sign_neg  = 1'($urandom_range(0, 1));
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bcd_scan_mux.md
BCD_SCAN_MUX -- requirements
Module: bcd_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 5: number of BCD digit positions, 1..15.
REQ-002 Parameter DIV, default 100000: refresh period per position in clk cycles, 2..2^24.
REQ-003 Parameter GUARD, default 2: anti-ghost blank cycles at the start of each position slot, 0..DIV-1.
REQ-004 Parameter LZB_EN, default 1: leading-zero blanking enable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 enable  input  1  scan enable.
REQ-008 digits_in  input  4*NUM_DIGITS  packed BCD; digit k is bits [4k+3:4k], digit 0 is least significant.
REQ-009 sign_neg  input  1  negative flag, captured with digits_in.
REQ-010 load  input  1  one-cycle strobe that captures digits_in and sign_neg.
REQ-011 digit_sel  output  NUM_DIGITS+1  one-hot active-low position select; bit NUM_DIGITS is the sign position.
REQ-012 digit_code  output  4  code for the selected position.
REQ-013 blank  output  1  high when the selected position is to be dark.
REQ-014 scan_idx  output  clog2(NUM_DIGITS+1)  current position index.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-016 pending  output  1  high while a captured value awaits frame-boundary transfer.

Function
REQ-017 Prescaler cnt SHALL count 0..DIV-1 while enable=1; tick SHALL be asserted in the cycle cnt==DIV-1, and cnt SHALL then wrap to 0.
REQ-018 On tick, scan_idx SHALL advance 0,1,...,NUM_DIGITS and then wrap to 0.
REQ-019 frame_done SHALL pulse for exactly the cycle in which scan_idx wraps from NUM_DIGITS to 0.
REQ-020 All outputs SHALL be registered and SHALL change on the same edge as cnt and scan_idx.
REQ-021 digit_sel bit scan_idx SHALL be 0 only when enable=1 and cnt>=GUARD; every other bit SHALL be 1, and all bits SHALL be 1 while cnt<GUARD.
REQ-022 Double buffering: load SHALL write digits_in and sign_neg into a pending buffer and set pending=1; a later load before transfer SHALL overwrite the pending buffer.
REQ-023 Transfer: on the frame_done edge with pending=1, the active buffer SHALL take the pending buffer and pending SHALL clear.
REQ-024 If load coincides with the frame_done edge, digits_in and sign_neg SHALL go directly to the active buffer and pending SHALL be 0 afterwards.
REQ-025 The display SHALL only ever show active-buffer contents, so no frame mixes two values.
REQ-026 Position k<NUM_DIGITS: digit_code SHALL equal active digit k; blank SHALL be 1 if LZB_EN=1, k>=1, and active digits k..NUM_DIGITS-1 are all 4'h0, otherwise 0.
REQ-027 Digit 0 SHALL never be leading-zero blanked; codes 10..15 SHALL pass through unchanged and SHALL count as nonzero.
REQ-028 Sign position: digit_code SHALL be 4'hA and blank 0 when the active sign is 1; otherwise digit_code SHALL be 4'h0 and blank 1.
REQ-029 With enable=0: cnt and scan_idx SHALL be held at 0, digit_sel SHALL be all 1, and frame_done SHALL be 0; load and pending SHALL keep operating but no transfer occurs.
REQ-030 When enable rises, scanning SHALL restart at cnt=0 and scan_idx=0.

Reset
REQ-031 While rst_n=0 at a clock edge: digit_sel all 1, digit_code 0, blank 1, scan_idx 0, frame_done 0, pending 0, cnt 0, both buffers 0, and sign 0.
REQ-032 Reset SHALL override load and enable, and SHALL abort any scan or pending transfer mid-frame.

Verification (NUM_DIGITS=4, DIV=4, GUARD=1, LZB_EN=1)
REQ-033 Reset, enable=1, no load -> digit_sel stays 5'b11111 for 1 cycle and then steps 11110, 11101, ... (each low for 3 of 4 cycles); blank=1 at positions 1..4 and 0 at position 0 with code 0; frame_done pulses every 20 cycles.
REQ-034 load digits 16'h0305 with sign_neg=1 mid-frame -> pending=1 until the next frame_done, then the display shows position 0 = 5, position 1 = 0 unblanked, position 2 = 3, position 3 blanked, sign = A.
REQ-035 load 16'h0012 and then 16'h0099 within the same frame -> only 0099 is displayed and 0012 never appears.
REQ-036 load asserted in the frame_done cycle with 16'h1234 -> the new frame shows 4,3,2,1 immediately and pending=0.
REQ-037 enable dropped mid-slot -> digit_sel goes to all 1 next edge and scan_idx to 0; enable raised again -> scanning restarts at position 0 with the guard cycle.
REQ-038 rst_n low for one cycle mid-frame with pending=1 -> all outputs and state return to REQ-031 values and the pending value is discarded.
